// File: rtl/dds_pwm_amplitude_gen.sv
// Amplitude PWM generator: turns a 16-bit duty target into a PWM drive for the analog filter.
// The duty is applied once per period, with an optional per-period slew limit.
module dds_pwm_amplitude_gen #(
    parameter int unsigned CNT_W     = 10,
    parameter int unsigned PRESCALE  = 1,
    parameter int unsigned SLEW_STEP = 64
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [15:0] amplitude,
    output logic        pwm_out,
    output logic        period_start,
    output logic [15:0] active_duty,
    output logic        ramping
);

    localparam int unsigned PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned STEP_SAT = (SLEW_STEP > 65535) ? 65535 : SLEW_STEP;

    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [16:0]      STEP_MAG = 17'(STEP_SAT);
    localparam logic [15:0]      STEP_16  = 16'(STEP_SAT);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    state_e             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        duty_q, duty_d;
    logic [15:0]        target_q, target_d;
    logic               pwm_q, pwm_d;
    logic               ps_q, ps_d;
    logic               ramp_q, ramp_d;

    logic               tick;
    logic               boundary;
    logic [CNT_W-1:0]   cmp;
    logic signed [16:0] diff;
    logic [16:0]        mag;
    logic [15:0]        slewed;

    assign cmp = duty_q[15 -: CNT_W];

    // Next duty toward the sampled amplitude; the step is only taken when it cannot overshoot.
    always_comb begin
        diff   = $signed({1'b0, amplitude}) - $signed({1'b0, duty_q});
        mag    = diff[16] ? $unsigned(-diff) : $unsigned(diff);
        slewed = amplitude;
        if ((SLEW_STEP != 0) && (mag > STEP_MAG)) begin
            if (diff[16]) begin
                slewed = duty_q - STEP_16;
            end else begin
                slewed = duty_q + STEP_16;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        pre_d    = pre_q;
        cnt_d    = cnt_q;
        duty_d   = duty_q;
        target_d = target_q;
        boundary = 1'b0;
        tick     = (pre_q == PRE_LAST);

        case (state_q)
            IDLE: begin
                pre_d  = '0;
                cnt_d  = '0;
                duty_d = '0;
                if (enable) begin
                    state_d  = RUN;
                    boundary = 1'b1;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_d = IDLE;
                    pre_d   = '0;
                    cnt_d   = '0;
                    duty_d  = '0;
                end else if (tick && (cnt_q == CNT_LAST)) begin
                    boundary = 1'b1;
                end else if (tick) begin
                    pre_d = '0;
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    pre_d = pre_q + PRE_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Amplitude is only sampled here, so mid-period writes wait for the next period.
        if (boundary) begin
            pre_d    = '0;
            cnt_d    = '0;
            target_d = amplitude;
            duty_d   = slewed;
        end

        ps_d   = boundary;
        pwm_d  = (state_q == RUN) && ((duty_q == 16'hFFFF) || (cnt_q < cmp));
        ramp_d = (state_d == RUN) && (duty_d != target_d);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pre_q    <= '0;
            cnt_q    <= '0;
            duty_q   <= '0;
            target_q <= '0;
            pwm_q    <= 1'b0;
            ps_q     <= 1'b0;
            ramp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pre_q    <= pre_d;
            cnt_q    <= cnt_d;
            duty_q   <= duty_d;
            target_q <= target_d;
            pwm_q    <= pwm_d;
            ps_q     <= ps_d;
            ramp_q   <= ramp_d;
        end
    end

    assign pwm_out      = pwm_q;
    assign period_start = ps_q;
    assign active_duty  = duty_q;
    assign ramping      = ramp_q;

endmodule

// File: tb/tb_dds_pwm_amplitude_gen.sv
// Bench for dds_pwm_amplitude_gen: three instances (plain, slew-limited, prescaled)
// checked cycle by cycle against a queue of expected per-clock outputs.
module tb_dds_pwm_amplitude_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        en_a, en_s, en_p;
    logic [15:0] amp_a, amp_s, amp_p;
    logic        pwm_a, pwm_s, pwm_p;
    logic        ps_a, ps_s, ps_p;
    logic [15:0] duty_a, duty_s, duty_p;
    logic        ramp_a, ramp_s, ramp_p;

    dds_pwm_amplitude_gen #(.CNT_W(4), .PRESCALE(1), .SLEW_STEP(0)) dut_a (
        .clk(clk), .reset_n(reset_n), .enable(en_a), .amplitude(amp_a),
        .pwm_out(pwm_a), .period_start(ps_a), .active_duty(duty_a), .ramping(ramp_a));

    dds_pwm_amplitude_gen #(.CNT_W(4), .PRESCALE(1), .SLEW_STEP(16'h1000)) dut_s (
        .clk(clk), .reset_n(reset_n), .enable(en_s), .amplitude(amp_s),
        .pwm_out(pwm_s), .period_start(ps_s), .active_duty(duty_s), .ramping(ramp_s));

    dds_pwm_amplitude_gen #(.CNT_W(4), .PRESCALE(3), .SLEW_STEP(0)) dut_p (
        .clk(clk), .reset_n(reset_n), .enable(en_p), .amplitude(amp_p),
        .pwm_out(pwm_p), .period_start(ps_p), .active_duty(duty_p), .ramping(ramp_p));

    typedef struct packed {
        logic        ps;
        logic        pwm;
        logic        ramp;
        logic [15:0] duty;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outputs k clocks after a period boundary edge (k = 0 is the boundary itself).
    // The pwm seen on the boundary edge belongs to the previous period's last count.
    function automatic exp_t exp_at(input logic [15:0] duty, input logic [15:0] target,
                                    input int k, input bit prev_full, input int pre);
        exp_t e;
        int   c;
        e.ps   = (k == 0);
        e.duty = duty;
        e.ramp = (duty != target);
        if (k == 0) begin
            e.pwm = prev_full;
        end else begin
            c     = (k - 1) / pre;
            e.pwm = (duty == 16'hFFFF) || (c < int'(duty[15:12]));
        end
        return e;
    endfunction

    task automatic push_period(input logic [15:0] duty, input logic [15:0] target,
                               input bit prev_full, input int pre);
        for (int k = 0; k < 16 * pre; k++) begin
            sb_q.push_back(exp_at(duty, target, k, prev_full, pre));
        end
    endtask

    task automatic idle_a();
        en_a = 1'b0;
        step();
        step();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        en_a = 1'b0; en_s = 1'b0; en_p = 1'b0;
        amp_a = 16'h0; amp_s = 16'h0; amp_p = 16'h0;
        #3;
        checks++;
        if ({pwm_a, ps_a, ramp_a, duty_a} !== 19'd0) begin
            errors++;
            $display("FAIL reset_a: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_a, ps_a, ramp_a, duty_a);
        end
        step();
        step();
        checks++;
        if ({pwm_s, ps_s, ramp_s, duty_s} !== 19'd0) begin
            errors++;
            $display("FAIL reset_s: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_s, ps_s, ramp_s, duty_s);
        end
        checks++;
        if ({pwm_p, ps_p, ramp_p, duty_p} !== 19'd0) begin
            errors++;
            $display("FAIL reset_p: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_p, ps_p, ramp_p, duty_p);
        end
        reset_n = 1'b1;
        amp_a = 16'h8000;
        step();
        step();
        checks++;
        if ({pwm_a, ps_a, ramp_a, duty_a} !== 19'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_a, ps_a, ramp_a, duty_a);
        end
    endtask

    task automatic test_basic_duty();
        exp_t e, got;
        amp_a = 16'h8000;
        en_a  = 1'b1;
        push_period(16'h8000, 16'h8000, 1'b0, 1);
        push_period(16'h8000, 16'h8000, 1'b0, 1);
        for (int i = 0; i < 32; i++) begin
            step();
            e = sb_q.pop_front();
            got = '{ps: ps_a, pwm: pwm_a, ramp: ramp_a, duty: duty_a};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL basic_duty cyc %0d: got ps=%b pwm=%b ramp=%b duty=%h, want ps=%b pwm=%b ramp=%b duty=%h",
                         i, got.ps, got.pwm, got.ramp, got.duty, e.ps, e.pwm, e.ramp, e.duty);
            end
        end
    endtask

    task automatic test_duty_extremes();
        exp_t        e, got;
        logic [15:0] vals[3];
        vals[0] = 16'hFFFF;
        vals[1] = 16'h0000;
        vals[2] = 16'h0FFF;
        for (int v = 0; v < 3; v++) begin
            idle_a();
            amp_a = vals[v];
            en_a  = 1'b1;
            push_period(vals[v], vals[v], 1'b0, 1);
            push_period(vals[v], vals[v], vals[v] == 16'hFFFF, 1);
            for (int i = 0; i < 32; i++) begin
                step();
                e = sb_q.pop_front();
                got = '{ps: ps_a, pwm: pwm_a, ramp: ramp_a, duty: duty_a};
                checks++;
                if (got !== e) begin
                    errors++;
                    $display("FAIL extreme_%h cyc %0d: got ps=%b pwm=%b ramp=%b duty=%h, want ps=%b pwm=%b ramp=%b duty=%h",
                             vals[v], i, got.ps, got.pwm, got.ramp, got.duty, e.ps, e.pwm, e.ramp, e.duty);
                end
            end
        end
    endtask

    task automatic test_mid_period_change();
        exp_t e, got;
        idle_a();
        amp_a = 16'h8000;
        en_a  = 1'b1;
        push_period(16'h8000, 16'h8000, 1'b0, 1);
        push_period(16'h4000, 16'h4000, 1'b0, 1);
        for (int i = 0; i < 32; i++) begin
            step();
            e = sb_q.pop_front();
            got = '{ps: ps_a, pwm: pwm_a, ramp: ramp_a, duty: duty_a};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL mid_change cyc %0d: got ps=%b pwm=%b ramp=%b duty=%h, want ps=%b pwm=%b ramp=%b duty=%h",
                         i, got.ps, got.pwm, got.ramp, got.duty, e.ps, e.pwm, e.ramp, e.duty);
            end
            if (i == 3) amp_a = 16'h4000;
        end
    endtask

    task automatic test_slew();
        exp_t        e, got;
        logic [15:0] d;
        amp_s = 16'h4000;
        en_s  = 1'b1;
        for (int j = 0; j < 5; j++) begin
            d = (j < 4) ? 16'((j + 1) * 16'h1000) : 16'h4000;
            push_period(d, 16'h4000, 1'b0, 1);
        end
        for (int i = 0; i < 80; i++) begin
            step();
            e = sb_q.pop_front();
            got = '{ps: ps_s, pwm: pwm_s, ramp: ramp_s, duty: duty_s};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL slew cyc %0d: got ps=%b pwm=%b ramp=%b duty=%h, want ps=%b pwm=%b ramp=%b duty=%h",
                         i, got.ps, got.pwm, got.ramp, got.duty, e.ps, e.pwm, e.ramp, e.duty);
            end
        end
    endtask

    task automatic test_prescale();
        exp_t e, got;
        amp_p = 16'h8000;
        en_p  = 1'b1;
        push_period(16'h8000, 16'h8000, 1'b0, 3);
        push_period(16'h8000, 16'h8000, 1'b0, 3);
        for (int i = 0; i < 96; i++) begin
            step();
            e = sb_q.pop_front();
            got = '{ps: ps_p, pwm: pwm_p, ramp: ramp_p, duty: duty_p};
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL prescale cyc %0d: got ps=%b pwm=%b ramp=%b duty=%h, want ps=%b pwm=%b ramp=%b duty=%h",
                         i, got.ps, got.pwm, got.ramp, got.duty, e.ps, e.pwm, e.ramp, e.duty);
            end
        end
    endtask

    task automatic test_reset_disable();
        bit found;
        // dut_a is still running at 0x4000; land mid-period, then reset between edges
        for (int i = 0; i < 5; i++) step();
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({pwm_a, ps_a, ramp_a, duty_a} !== 19'd0) begin
            errors++;
            $display("FAIL async_reset_a: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_a, ps_a, ramp_a, duty_a);
        end
        checks++;
        if ({pwm_s, ps_s, ramp_s, duty_s, pwm_p, duty_p} !== 36'd0) begin
            errors++;
            $display("FAIL async_reset_sp: got pwm_s=%b ps_s=%b ramp_s=%b duty_s=%h pwm_p=%b duty_p=%h, want all 0",
                     pwm_s, ps_s, ramp_s, duty_s, pwm_p, duty_p);
        end
        step();
        reset_n = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 2 && !found; i++) begin
            step();
            if (ps_a === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL restart_period_start: got no period_start in 2 clocks, want one");
        end
        checks++;
        if (duty_a !== 16'h4000) begin
            errors++;
            $display("FAIL restart_duty: got %h, want 4000", duty_a);
        end
        for (int i = 0; i < 4; i++) step();
        en_a = 1'b0;
        step();
        step();
        checks++;
        if ({pwm_a, ps_a, ramp_a, duty_a} !== 19'd0) begin
            errors++;
            $display("FAIL disable_a: got pwm=%b ps=%b ramp=%b duty=%h, want all 0", pwm_a, ps_a, ramp_a, duty_a);
        end
        // slew instance must soft-start from zero after a disable
        en_s = 1'b0;
        step();
        step();
        checks++;
        if ({pwm_s, ramp_s, duty_s} !== 18'd0) begin
            errors++;
            $display("FAIL disable_s: got pwm=%b ramp=%b duty=%h, want all 0", pwm_s, ramp_s, duty_s);
        end
        en_s = 1'b1;
        step();
        checks++;
        if ({ps_s, ramp_s, duty_s} !== {1'b1, 1'b1, 16'h1000}) begin
            errors++;
            $display("FAIL soft_start: got ps=%b ramp=%b duty=%h, want ps=1 ramp=1 duty=1000", ps_s, ramp_s, duty_s);
        end
    endtask

    initial begin
        test_reset();
        test_basic_duty();
        test_duty_extremes();
        test_mid_period_change();
        test_slew();
        test_prescale();
        test_reset_disable();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
